// File: rtl/reg_bank_pkg.sv
// Shared defaults and helpers for the multi-port register bank.
// Reset contents are the register index, so a fresh bank is easy to recognise on reads.
package reg_bank_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [31:0] reset_val(input int i);
    return 32'(i);
  endfunction

endpackage

// File: rtl/reg_bank_byte_merge.sv
// Combinational byte merge of an old register value with two byte-enabled writes.
// Port 1 (ALU) wins on any byte it enables; port 0 (load writeback) fills the rest.
module reg_bank_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_val,
  input  logic                wr0_hit,
  input  logic [DATA_W/8-1:0] wr0_be,
  input  logic [DATA_W-1:0]   wr0_data,
  input  logic                wr1_hit,
  input  logic [DATA_W/8-1:0] wr1_be,
  input  logic [DATA_W-1:0]   wr1_data,
  output logic [DATA_W-1:0]   new_val
);

  localparam int BE_W = DATA_W / 8;

  always_comb begin
    new_val = old_val;
    for (int b = 0; b < BE_W; b++) begin
      if (wr1_hit && wr1_be[b])
        new_val[b*8 +: 8] = wr1_data[b*8 +: 8];
      else if (wr0_hit && wr0_be[b])
        new_val[b*8 +: 8] = wr0_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: NUM_RD registered read ports, two prioritised byte-enabled
// write ports and a per-register pending-write scoreboard for the decode/writeback paths.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = clog2(NUM_REGS),
  localparam int BE_W    = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr0_en,
  input  logic [AW-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic [BE_W-1:0]          wr0_be,
  input  logic                     wr1_en,
  input  logic [AW-1:0]            wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [BE_W-1:0]          wr1_be,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr
);

  logic [DATA_W-1:0]   regs   [NUM_REGS];
  logic [DATA_W-1:0]   merged [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [NUM_REGS-1:0] hit0;
  logic [NUM_REGS-1:0] hit1;

  // A reservation in the same cycle as a write names a newer producer, so it wins.
  always_comb begin
    hit0     = '0;
    hit1     = '0;
    pend_nxt = pend;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG && i == 0)) begin
        hit0[i] = wr0_en && (wr0_addr == AW'(i));
        hit1[i] = wr1_en && (wr1_addr == AW'(i));
        if (hit0[i] || hit1[i])
          pend_nxt[i] = 1'b0;
        if (rsv_en && (rsv_addr == AW'(i)))
          pend_nxt[i] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg_bank_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .old_val  (regs[i]),
      .wr0_hit  (hit0[i]),
      .wr0_be   (wr0_be),
      .wr0_data (wr0_data),
      .wr1_hit  (hit1[i]),
      .wr1_be   (wr1_be),
      .wr1_data (wr1_data),
      .new_val  (merged[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_W'(reset_val(i));
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= merged[i];
      pend <= pend_nxt;
    end
  end

  // With BYPASS the merged array doubles as the same-cycle forwarding source.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data_q;
    logic              pend_q;

    assign addr = rd_addr[p*AW +: AW];

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        pend_q <= 1'b0;
      end else if (rd_en[p]) begin
        data_q <= BYPASS ? merged[addr]   : regs[addr];
        pend_q <= BYPASS ? pend_nxt[addr] : pend[addr];
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_pend[p]                  = pend_q;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: two instances (bypass+zero-reg, and neither) on shared stimulus,
// checked against an array model that applies each cycle's writes one after another.
module tb_reg_bank_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic        wr0_en, wr1_en, rsv_en;
  logic [2:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [3:0]  wr0_be, wr1_be;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_pend_a, rd_pend_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank_mp dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_pend(rd_pend_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  reg_bank_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_pend(rd_pend_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  // Model state: config 0 = dut_a (zero reg, bypass), config 1 = dut_b (neither).
  logic [31:0] m_regs [2][8];
  logic        m_pend [2][8];
  logic [31:0] e_data [2][2];
  logic        e_pend [2][2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++)
      if (be[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic model_step();
    logic [31:0] nv [8];
    logic        np [8];
    logic        zr, byp;
    int          a;
    for (int c = 0; c < 2; c++) begin
      zr  = (c == 0);
      byp = (c == 0);
      for (int r = 0; r < 8; r++) begin
        nv[r] = m_regs[c][r];
        np[r] = m_pend[c][r];
      end
      // Port 0 first, then port 1 on top: the later write owns any byte both enable.
      if (wr0_en && !(zr && wr0_addr == 3'd0)) begin
        nv[wr0_addr] = (nv[wr0_addr] & ~be_mask(wr0_be)) | (wr0_data & be_mask(wr0_be));
        np[wr0_addr] = 1'b0;
      end
      if (wr1_en && !(zr && wr1_addr == 3'd0)) begin
        nv[wr1_addr] = (nv[wr1_addr] & ~be_mask(wr1_be)) | (wr1_data & be_mask(wr1_be));
        np[wr1_addr] = 1'b0;
      end
      if (rsv_en && !(zr && rsv_addr == 3'd0))
        np[rsv_addr] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          a = int'(rd_addr[p*3 +: 3]);
          e_data[c][p] = byp ? nv[a] : m_regs[c][a];
          e_pend[c][p] = byp ? np[a] : m_pend[c][a];
        end
      end
      if (rst) begin
        for (int r = 0; r < 8; r++) begin
          m_regs[c][r] = 32'(r);
          m_pend[c][r] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
          e_data[c][p] = 32'h0;
          e_pend[c][p] = 1'b0;
        end
      end else begin
        for (int r = 0; r < 8; r++) begin
          m_regs[c][r] = nv[r];
          m_pend[c][r] = np[r];
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_data a p%0d", p), rd_data_a[p*32 +: 32], e_data[0][p]);
      chk($sformatf("rd_pend a p%0d", p), 32'(rd_pend_a[p]), 32'(e_pend[0][p]));
      chk($sformatf("rd_data b p%0d", p), rd_data_b[p*32 +: 32], e_data[1][p]);
      chk($sformatf("rd_pend b p%0d", p), 32'(rd_pend_b[p]), 32'(e_pend[1][p]));
    end
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = 2'b00; rd_addr = 6'h0;
    wr0_en = 1'b0; wr0_addr = 3'd0; wr0_data = 32'h0; wr0_be = 4'h0;
    wr1_en = 1'b0; wr1_addr = 3'd0; wr1_data = 32'h0; wr1_be = 4'h0;
    rsv_en = 1'b0; rsv_addr = 3'd0;
  endtask

  task automatic rd2(input logic [2:0] a0, input logic [2:0] a1);
    rd_en = 2'b11;
    rd_addr = {a1, a0};
  endtask

  initial begin
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) begin
        e_data[c][p] = 32'h0;
        e_pend[c][p] = 1'b0;
      end
    idle();
    rst = 1'b1;
    step();
    step();
    idle();

    rd2(3'd3, 3'd7);
    step();
    chk("reset reg3", rd_data_a[31:0], 32'd3);
    chk("reset reg7", rd_data_a[63:32], 32'd7);
    rd2(3'd0, 3'd0);
    step();
    chk("reset reg0", rd_data_a[31:0], 32'd0);

    idle();
    wr1_en = 1'b1; wr1_addr = 3'd2; wr1_data = 32'hAABBCCDD; wr1_be = 4'hF;
    rd2(3'd2, 3'd2);
    step();
    chk("bypass same cycle", rd_data_a[31:0], 32'hAABBCCDD);
    chk("no bypass same cycle", rd_data_b[31:0], 32'd2);
    idle();
    rd2(3'd2, 3'd2);
    step();
    chk("no bypass next cycle", rd_data_b[63:32], 32'hAABBCCDD);

    idle();
    wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 32'h11223344; wr0_be = 4'hF;
    wr1_en = 1'b1; wr1_addr = 3'd5; wr1_data = 32'hFFFFFFFF; wr1_be = 4'h3;
    step();
    idle();
    rd2(3'd5, 3'd5);
    step();
    chk("dual write merge", rd_data_a[31:0], 32'h1122FFFF);

    idle();
    wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 32'hDEADBEEF; wr0_be = 4'hF;
    step();
    idle();
    rd2(3'd0, 3'd0);
    step();
    chk("zero reg drops write", rd_data_a[31:0], 32'h0);
    chk("plain reg0 write", rd_data_b[31:0], 32'hDEADBEEF);

    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    step();
    idle();
    rd2(3'd4, 3'd4);
    step();
    chk("reserve sets pend", 32'(rd_pend_a[0]), 32'd1);
    idle();
    wr0_en = 1'b1; wr0_addr = 3'd4; wr0_data = 32'h12345678; wr0_be = 4'h0;
    step();
    idle();
    rd2(3'd4, 3'd4);
    step();
    chk("be0 write clears pend", 32'(rd_pend_a[0]), 32'd0);
    chk("be0 write keeps data", rd_data_a[31:0], 32'd4);
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 32'h0; wr1_be = 4'hF;
    step();
    idle();
    rd2(3'd4, 3'd4);
    step();
    chk("reserve beats write", 32'(rd_pend_b[1]), 32'd1);

    idle();
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 3'd6; wr0_data = 32'h55; wr0_be = 4'hF;
    rsv_en = 1'b1; rsv_addr = 3'd6;
    rd2(3'd6, 3'd4);
    step();
    chk("rst clears rd_data", rd_data_a[31:0], 32'h0);
    idle();
    rd2(3'd6, 3'd4);
    step();
    chk("rst drops write", rd_data_a[31:0], 32'd6);
    chk("rst clears pend", 32'(rd_pend_a[1]), 32'd0);

    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      rd_en    = 2'($urandom);
      rd_addr  = 6'($urandom);
      wr0_en   = 1'($urandom);
      wr0_addr = 3'($urandom);
      wr0_data = $urandom;
      wr0_be   = 4'($urandom);
      wr1_en   = 1'($urandom);
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 3'($urandom);
      wr1_data = $urandom;
      wr1_be   = 4'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wr1_addr : 3'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-port register file, successor to the 8×32 two-read/one-write register bank. Provides NUM_RD registered read ports, two prioritised byte-enabled write ports, optional hard-wired zero register, optional write-to-read bypass, and a per-register pending-write scoreboard. Sits between the decode stage (read/reserve) and the ALU/load writeback paths (write) of the datapath.

## Interface

- DATA_W, 32, register width in bits; multiple of 8
- NUM_REGS, 8, number of registers; power of two, ≥ 2
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations
- BYPASS, 1, 1 = a same-cycle write is visible on a read issued that cycle
- AW (derived), $clog2(NUM_REGS), address width; BE_W (derived) = DATA_W/8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*AW  packed read addresses, port p at [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_pend  out  NUM_RD  registered pending bit of the addressed register
- wr0_en / wr1_en  in  1  write strobes; port 1 is ALU, port 0 is load writeback
- wr0_addr / wr1_addr  in  AW  write addresses
- wr0_data / wr1_data  in  DATA_W  write data
- wr0_be / wr1_be  in  BE_W  byte enables
- rsv_en  in  1  mark a register pending (producer issued)
- rsv_addr  in  AW  register to reserve

## Operation

- Reset: regs[i] = i (zero-extended) for all i; regs[0] = 0; all pending bits 0; rd_data = 0; rd_pend = 0.
- Write: byte b of regs[a] updated when wrX_en, wrX_addr == a, wrX_be[b]. Both ports to same address: per byte, port 1 wins where wr1_be[b]=1, else port 0 byte applies.
- Write with wrX_be = 0 is a no-op for data but still clears pending (see below).
- ZERO_REG=1: writes and reservations to address 0 dropped; reads of 0 return 0, rd_pend 0.
- Read: when rd_en[p], rd_data[p] ← regs[rd_addr[p]] and rd_pend[p] ← pend[rd_addr[p]]; when rd_en[p]=0 both hold previous value.
- BYPASS=1: read data is the post-write merged value (including byte merge across both ports) and pending is the post-update value. BYPASS=0: pre-write value and pre-update pending.
- Scoreboard: rsv_en sets pend[rsv_addr]; any enabled write to an address clears its pend bit. Reserve and write to same address same cycle → pend stays 1 (new producer wins).
- Multiple read ports may address the same register; all return the same value.

## Timing

- Read latency 1 cycle: address at edge n, data valid after edge n+1 until next enabled read.
- Write latency 1 cycle: visible to reads issued next cycle (same cycle if BYPASS=1).
- rst asserted on edge overrides all write, reserve and read activity that edge; mid-operation reset discards in-flight writes.
- No combinational path from inputs to outputs; all outputs are flops.

## Structure

- Package reg_bank_pkg: default DATA_W/NUM_REGS constants, clog2 helper, reset-value function reset_val(i).
- Sub-module reg_bank_byte_merge: combinational merge of old value with two byte-enabled writes under port-1 priority; instantiated once per register (and reused for the bypass path).
- Storage as unpacked array of NUM_REGS × DATA_W flops plus NUM_REGS pending flops; read ports generated by a generate loop.

## Test plan

- Reset then read ports 0..1 at addr 3 and 7 → rd_data = 3, 7; rd_pend = 0; reg 0 reads 0.
- wr1 addr 2 data 0xAABBCCDD be 1111, read addr 2 next cycle → 0xAABBCCDD; same-cycle read gives 0xAABBCCDD (BYPASS=1) vs 2 (BYPASS=0).
- Both ports to addr 5, wr0 data 0x11223344 be 1111, wr1 data 0xFFFFFFFF be 0011 → reg5 = 0x1122FFFF.
- Write 0xDEADBEEF to addr 0 with ZERO_REG=1 → reads 0; ZERO_REG=0 → reads 0xDEADBEEF.
- rsv addr 4 → rd_pend=1 on read of 4; wr0 addr 4 be 0000 → pend cleared, data still 4; rsv+write addr 4 same cycle → pend 1.
- Write addr 6 data 0x55 while rst=1 → after reset regs[6]=6, rd_data 0, all pend 0.
